dec_scan_sequencer: RTL and testbench
=====================================

Name: dec_scan_sequencer

Overview:
- Upstream driver for the 4-to-16 line decoder; generates its a,b,c,d select code plus the enable.
- Steps through the 16 decoder lines in ascending order, skipping masked-off lines, holding each line for a programmable dwell time.
- Supports one-shot and continuous (wrap-around) scanning, with start/stop control and done/wrap status pulses.

Parameters:
DWELL_W, 8, width of the dwell-count input and internal dwell counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  begin a scan when idle (level sampled each cycle)
stop  input  1  abort the scan; returns to idle next cycle
cont  input  1  1 = continuous scan with wrap, 0 = one-shot; latched at start
dwell  input  DWELL_W  cycles to hold each line; 0 treated as 1; latched at start
mask  input  16  bit k = 1 enables line k; latched at start
a  output  1  select MSB (bit 3), registered
b  output  1  select bit 2, registered
c  output  1  select bit 1, registered
d  output  1  select LSB (bit 0), registered
en  output  1  decoder enable; 1 only while a line is being driven
busy  output  1  1 while the FSM is in SCAN
done  output  1  one-cycle pulse when a one-shot scan completes
wrap  output  1  one-cycle pulse when a continuous scan wraps to the first line

Behaviour:
- All outputs registered. On rst: FSM = IDLE; {a,b,c,d} = 0; en, busy, done and wrap = 0; dwell counter = 0; latched mask/dwell/cont = 0.
- Select code: idx = {a,b,c,d}, so a is the MSB.
- FSM states: IDLE and SCAN.
- IDLE, start=1, stop=0, mask != 0:
  - Latch mask, cont and dwell_eff = max(dwell,1).
  - Next cycle: SCAN; idx = lowest set bit of mask; en = 1; busy = 1; counter = dwell_eff - 1.
  - Latency from start to en = 1 is one clock.
- IDLE, start=1, mask == 0: start ignored; stays IDLE; no pulses.
- SCAN, counter != 0: decrement the counter; idx and en hold.
- SCAN, counter == 0 (end of dwell): next = lowest enabled line strictly above idx in the latched mask.
  - next exists: idx = next; counter reloads to dwell_eff - 1; en stays 1 (no gap cycle).
  - No next, cont = 1: idx = lowest enabled line; counter reloads; wrap = 1 for that one cycle.
  - No next, cont = 0: go to IDLE; en = 0; busy = 0; done = 1 for one cycle; idx holds the last line.
- Each enabled line is therefore driven for exactly dwell_eff cycles.
- A single enabled line with cont = 1: idx stays constant; wrap pulses every dwell_eff cycles.
- stop = 1 in any state: next cycle IDLE; en = 0; busy = 0; no done or wrap; idx holds.
- stop and start in the same cycle: stop wins.
- start while busy: ignored.
- mask, dwell and cont changes during SCAN have no effect until the next start.
- The done cycle and the following IDLE cycle accept a new start, so back-to-back scans are allowed: start is sampled in the cycle where done = 1.
- rst mid-scan: immediate return to the reset values at the clock edge; takes priority over all other inputs.
- Search for the next enabled line is combinational over 16 bits (priority find); no multi-cycle seek.

Optional Feature:
- Macro: DEC_SCAN_HOLD_EN.
- Defined: adds input port hold (1 bit). While hold = 1 in SCAN, the dwell counter freezes and idx and en hold; no advance, wrap or done occurs. stop and rst still take priority over hold. hold has no effect in IDLE.
- Undefined: no hold port; behaviour is identical to hold tied to 0.

Test Plan:
- rst high for 2 cycles mid-scan -> next cycle a,b,c,d = 0, en = 0, busy = 0, done = 0, wrap = 0.
- mask=16'hFFFF, dwell=1, cont=0, start pulse -> idx runs 0,1,...,15, one cycle each; en = 1 for 16 cycles; done pulses the cycle after idx = 15; idx stays 15.
- mask=16'h8421, dwell=3, cont=1 -> idx 0,5,10,15, three cycles each, then 0 again with wrap = 1 on that cycle; repeats.
- mask=16'h0010, dwell=0, cont=1 -> idx = 4 constant; en = 1; wrap = 1 every cycle (dwell treated as 1).
- mask=16'h00F0, dwell=4; stop asserted on the 2nd cycle of idx = 5 -> next cycle en = 0, busy = 0, idx = 5, no done. start and stop together from IDLE -> stays IDLE. start with mask=0 -> no activity.
- With DEC_SCAN_HOLD_EN: mask=16'h0003, dwell=2, hold high for 5 cycles during idx = 0 -> idx = 0 held for 7 cycles total, then idx = 1, then done.

Source files
------------

// File: rtl/dec_scan_sequencer_if.sv
// Control/status bundle between a scan controller and dec_scan_sequencer.
// Optional hold input is present only when DEC_SCAN_HOLD_EN is defined.
interface dec_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic [15:0]        mask;
`ifdef DEC_SCAN_HOLD_EN
  logic               hold;
`endif
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic               en;
  logic               busy;
  logic               done;
  logic               wrap;

`ifdef DEC_SCAN_HOLD_EN
  modport master (output start, stop, cont, dwell, mask, hold,
                  input  a, b, c, d, en, busy, done, wrap);
  modport slave  (input  start, stop, cont, dwell, mask, hold,
                  output a, b, c, d, en, busy, done, wrap);
`else
  modport master (output start, stop, cont, dwell, mask,
                  input  a, b, c, d, en, busy, done, wrap);
  modport slave  (input  start, stop, cont, dwell, mask,
                  output a, b, c, d, en, busy, done, wrap);
`endif
endinterface

// File: rtl/dec_scan_sequencer.sv
// Drives a 4-to-16 decoder select code through the enabled lines, dwell cycles each.
// Optional feature macro: DEC_SCAN_HOLD_EN (adds a hold input that freezes the scan).
module dec_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dec_scan_sequencer_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_nxt;
  logic [3:0]         idx, idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] lat_dwell, lat_dwell_nxt;
  logic [15:0]        lat_mask, lat_mask_nxt;
  logic               lat_cont, lat_cont_nxt;
  logic               en_q, en_nxt;
  logic               done_q, done_nxt;
  logic               wrap_q, wrap_nxt;

  logic               hold_act;
  logic [DWELL_W-1:0] dwell_eff;
  logic [15:0]        above;
  logic               next_found;
  logic [3:0]         next_idx;
  logic [3:0]         first_in;
  logic [3:0]         first_lat;

  // Lowest set bit; callers guarantee a nonzero operand where the result matters.
  function automatic logic [3:0] find_first(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

`ifdef DEC_SCAN_HOLD_EN
  assign hold_act = bus.hold;
`else
  assign hold_act = 1'b0;
`endif

  assign dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  // Bits strictly above idx; shifting past bit 15 yields all-zero for idx = 15.
  assign above      = ~((16'd2 << idx) - 16'd1);
  assign next_found = |(lat_mask & above);
  assign next_idx   = find_first(lat_mask & above);
  assign first_in   = find_first(bus.mask);
  assign first_lat  = find_first(lat_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      cnt       <= '0;
      lat_dwell <= '0;
      lat_mask  <= 16'd0;
      lat_cont  <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      lat_dwell <= lat_dwell_nxt;
      lat_mask  <= lat_mask_nxt;
      lat_cont  <= lat_cont_nxt;
      en_q      <= en_nxt;
      done_q    <= done_nxt;
      wrap_q    <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!bus.stop && bus.start && (bus.mask != 16'd0)) state_nxt = SCAN;
      SCAN: begin
        if (bus.stop) state_nxt = IDLE;
        else if (!hold_act && (cnt == '0) && !next_found && !lat_cont) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    lat_dwell_nxt = lat_dwell;
    lat_mask_nxt  = lat_mask;
    lat_cont_nxt  = lat_cont;
    done_nxt      = 1'b0;
    wrap_nxt      = 1'b0;
    en_nxt        = (state_nxt == SCAN);
    case (state)
      IDLE: begin
        if (state_nxt == SCAN) begin
          lat_mask_nxt  = bus.mask;
          lat_cont_nxt  = bus.cont;
          lat_dwell_nxt = dwell_eff;
          idx_nxt       = first_in;
          cnt_nxt       = dwell_eff - 1'b1;
        end
      end
      SCAN: begin
        if (!bus.stop && !hold_act) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (next_found) begin
            idx_nxt = next_idx;
            cnt_nxt = lat_dwell - 1'b1;
          end else if (lat_cont) begin
            idx_nxt  = first_lat;
            cnt_nxt  = lat_dwell - 1'b1;
            wrap_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.a    = idx[3];
  assign bus.b    = idx[2];
  assign bus.c    = idx[1];
  assign bus.d    = idx[0];
  assign bus.en   = en_q;
  assign bus.busy = (state == SCAN);
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Directed bench for dec_scan_sequencer; status compared as {idx,en,busy,done,wrap}.
// Hold scenario is exercised only when DEC_SCAN_HOLD_EN is defined.
module tb_dec_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dec_scan_sequencer_if #(.DWELL_W(8)) bus ();

  dec_scan_sequencer #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] obs;
  assign obs = {bus.a, bus.b, bus.c, bus.d, bus.en, bus.busy, bus.done, bus.wrap};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    bus.mask = 16'hFFFF; bus.dwell = 8'd5; bus.cont = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_prescan obs=%h exp=%h", obs, exp);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_cycle%0d obs=%h exp=00", i, obs);
      end
    end
    rst = 1'b0;
    step();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release obs=%h exp=00", obs);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp;
    bus.mask = 16'hFFFF; bus.dwell = 8'd1; bus.cont = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp = {4'(k), 1'b1, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL oneshot_line%0d obs=%h exp=%h", k, obs, exp);
      end
      step();
    end
    exp = {4'd15, 1'b0, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL oneshot_done obs=%h exp=%h", obs, exp);
    end
    step();
    exp = {4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL oneshot_after obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] exp;
    logic [3:0] lines [4];
    lines[0] = 4'd0; lines[1] = 4'd5; lines[2] = 4'd10; lines[3] = 4'd15;
    bus.mask = 16'h8421; bus.dwell = 8'd3; bus.cont = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mask = 16'h0000; bus.dwell = 8'd1; bus.cont = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int l = 0; l < 4; l++) begin
        for (int t = 0; t < 3; t++) begin
          exp = {lines[l], 1'b1, 1'b1, 1'b0, (r > 0 && l == 0 && t == 0)};
          vectors++;
          if (obs !== exp) begin
            miscompares++;
            $display("FAIL cont_r%0d_l%0d_t%0d obs=%h exp=%h", r, l, t, obs, exp);
          end
          step();
        end
      end
    end
    exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL cont_third_wrap obs=%h exp=%h", obs, exp);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    exp = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL cont_stop obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_single_wrap();
    logic [7:0] exp;
    bus.mask = 16'h0010; bus.dwell = 8'd0; bus.cont = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = {4'd4, 1'b1, 1'b1, 1'b0, (i != 0)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_cyc%0d obs=%h exp=%h", i, obs, exp);
      end
      step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    exp = {4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL single_stop obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_stop();
    logic [7:0] exp;
    bus.mask = 16'h00F0; bus.dwell = 8'd4; bus.cont = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {(i < 4) ? 4'd4 : 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stop_run%0d obs=%h exp=%h", i, obs, exp);
      end
      if (i == 5) bus.stop = 1'b1;
      step();
    end
    bus.stop = 1'b0;
    exp = {4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL stop_idle obs=%h exp=%h", obs, exp);
    end
    step();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL stop_no_done obs=%h exp=%h", obs, exp);
    end
    bus.mask = 16'hFFFF; bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL start_stop_same obs=%h exp=%h", obs, exp);
    end
    bus.mask = 16'h0000; bus.start = 1'b1;
    step(); step();
    bus.start = 1'b0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL start_mask0 obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    exp[0] = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp[1] = {4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp[2] = {4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp[3] = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp[4] = {4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp[5] = {4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.mask = 16'h0003; bus.dwell = 8'd1; bus.cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) bus.start = 1'b0;
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
    end
  endtask

`ifdef DEC_SCAN_HOLD_EN
  task automatic test_hold();
    logic [7:0] exp;
    bus.mask = 16'h0003; bus.dwell = 8'd2; bus.cont = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.hold = (i >= 1 && i <= 5);
      if (i < 7)       exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      else if (i < 9)  exp = {4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      else             exp = {4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL hold_cyc%0d obs=%h exp=%h", i, obs, exp);
      end
      step();
    end
    bus.hold = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
    bus.dwell = 8'd0; bus.mask = 16'd0;
`ifdef DEC_SCAN_HOLD_EN
    bus.hold = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_one_shot();
    test_continuous();
    test_single_wrap();
    test_stop();
    test_back_to_back();
`ifdef DEC_SCAN_HOLD_EN
    test_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
